// File: rtl/memory_param_sweep_pkg.sv
// Shared definitions for the sweep-clear memory: default geometry and the
// controller state encoding.
package memory_param_sweep_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_e;

endpackage

// File: rtl/memory_param_sweep_ctrl.sv
// Clear-sweep controller: walks a word pointer across the whole array,
// one word per clock, and flags the walk with busy.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | normal access allowed; a clear request starts a sweep
//  ST_SWEEP | word cnt_q is overwritten this edge; accesses are dropped
module memory_param_sweep_ctrl
   import memory_param_sweep_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              clear_i,
   output logic              busy_o,
   output logic              sweep_we_o,
   output logic [ADDR_W-1:0] sweep_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   sweep_state_e      state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;
   logic              busy_q;

   assign cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   // FSM, sweep pointer and registered busy flag; the last word ends the
   // sweep and parks the pointer back at zero.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clear_i) begin
                  state_q <= ST_SWEEP;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            ST_SWEEP: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign busy_o       = busy_q;
   assign sweep_we_o   = busy_q;
   assign sweep_addr_o = cnt_q;

endmodule

// File: rtl/memory_param_sweep.sv
// Single-port synchronous memory with per-bit write mask, registered read
// plus valid strobe, selectable read-during-write bypass and a clear sweep.
module memory_param_sweep
   import memory_param_sweep_pkg::*;
#(
   parameter int unsigned       DATA_W    = DEF_DATA_W,
   parameter int unsigned       ADDR_W    = DEF_ADDR_W,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
   parameter bit                BYPASS    = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] d_in_i,
   input  logic [DATA_W-1:0] wmask_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              r_enable_i,
   input  logic              w_enable_i,
   input  logic              clear_i,
   output logic [DATA_W-1:0] d_out_o,
   output logic              r_valid_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] d_out_q;
   logic [DATA_W-1:0] d_out_d;
   logic              r_valid_q;
   logic              r_valid_d;
   logic              err_q;

   logic              busy;
   logic              sweep_we;
   logic [ADDR_W-1:0] sweep_addr;
   logic              access_ok;
   logic              access_req;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] merged_word;

   memory_param_sweep_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_ctrl (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clear_i      (clear_i),
      .busy_o       (busy),
      .sweep_we_o   (sweep_we),
      .sweep_addr_o (sweep_addr)
   );

   // A clear request in the same cycle as an access takes priority.
   assign access_ok   = !busy && !clear_i;
   assign access_req  = r_enable_i || w_enable_i;
   assign old_word    = mem_q[addr_i];
   assign merged_word = (old_word & ~wmask_i) | (d_in_i & wmask_i);

   // Storage: sweep writes and normal writes never coincide, since the
   // sweep only runs while busy blocks access.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= CLEAR_VAL;
         end
      end else if (sweep_we) begin
         mem_q[sweep_addr] <= CLEAR_VAL;
      end else if (access_ok && w_enable_i) begin
         mem_q[addr_i] <= merged_word;
      end
   end

   // Read data selection; the bypass picks the merged word on a same-cycle write.
   always_comb begin
      d_out_d   = d_out_q;
      r_valid_d = 1'b0;
      if (access_ok && r_enable_i) begin
         r_valid_d = 1'b1;
         if (BYPASS && w_enable_i) begin
            d_out_d = merged_word;
         end else begin
            d_out_d = old_word;
         end
      end
   end

   // Read register and valid strobe.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         d_out_q   <= '0;
         r_valid_q <= 1'b0;
      end else begin
         d_out_q   <= d_out_d;
         r_valid_q <= r_valid_d;
      end
   end

   // Sticky error: any access lost to a sweep or to a competing clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
      end else if (access_req && (busy || clear_i)) begin
         err_q <= 1'b1;
      end
   end

   assign d_out_o   = d_out_q;
   assign r_valid_o = r_valid_q;
   assign busy_o    = busy;
   assign err_o     = err_q;

endmodule

// File: tb/tb_memory_param_sweep.sv
// Bench for memory_param_sweep: two instances (bypass on / off) share the
// same stimulus and are compared against an array-based reference model.
module tb_memory_param_sweep;

   logic       clk;
   logic       rst_n;
   logic [7:0] d_in;
   logic [7:0] wmask;
   logic [2:0] addr;
   logic       r_en;
   logic       w_en;
   logic       clr;

   logic [7:0] d_out_b, d_out_n;
   logic       rv_b, rv_n, busy_b, busy_n, err_b, err_n;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [7:0] m_mem [8];
   logic [7:0] m_d1, m_d0;
   logic       m_rv, m_busy, m_err;
   int         m_left, m_idx;

   memory_param_sweep #(.DATA_W(8), .ADDR_W(3), .CLEAR_VAL(8'h00), .BYPASS(1'b1)) u_dut_byp (
      .clk_i(clk), .rst_n_i(rst_n), .d_in_i(d_in), .wmask_i(wmask), .addr_i(addr),
      .r_enable_i(r_en), .w_enable_i(w_en), .clear_i(clr),
      .d_out_o(d_out_b), .r_valid_o(rv_b), .busy_o(busy_b), .err_o(err_b)
   );

   memory_param_sweep #(.DATA_W(8), .ADDR_W(3), .CLEAR_VAL(8'h00), .BYPASS(1'b0)) u_dut_nobyp (
      .clk_i(clk), .rst_n_i(rst_n), .d_in_i(d_in), .wmask_i(wmask), .addr_i(addr),
      .r_enable_i(r_en), .w_enable_i(w_en), .clear_i(clr),
      .d_out_o(d_out_n), .r_valid_o(rv_n), .busy_o(busy_n), .err_o(err_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r, w, c;
      logic [2:0] a;
      logic [7:0] d, m;
      logic [7:0] exp_d1, exp_d0;
      logic       exp_rv;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_d1 = 8'h00; m_d0 = 8'h00;
      m_rv = 1'b0; m_busy = 1'b0; m_err = 1'b0;
      m_left = 0; m_idx = 0;
   endtask

   task automatic model_step(input logic r, input logic w, input logic c,
                             input logic [2:0] a, input logic [7:0] d, input logic [7:0] m);
      logic [7:0] old_w, new_w;
      if (m_busy) begin
         if (r || w) m_err = 1'b1;
         m_mem[m_idx] = 8'h00;
         m_idx++;
         m_left--;
         if (m_left == 0) m_busy = 1'b0;
         m_rv = 1'b0;
      end else if (c) begin
         m_busy = 1'b1;
         m_left = 8;
         m_idx  = 0;
         if (r || w) m_err = 1'b1;
         m_rv = 1'b0;
      end else begin
         old_w = m_mem[a];
         new_w = (old_w & ~m) | (d & m);
         if (w) m_mem[a] = new_w;
         m_rv = r;
         if (r) begin
            m_d1 = w ? new_w : old_w;
            m_d0 = old_w;
         end
      end
   endtask

   // Called just after an active edge: drive, advance model, clock, sample.
   task automatic cycle(input logic r, input logic w, input logic c,
                        input logic [2:0] a, input logic [7:0] d, input logic [7:0] m);
      r_en = r; w_en = w; clr = c; addr = a; d_in = d; wmask = m;
      model_step(r, w, c, a, d, m);
      @(posedge clk);
      #1;
      check("dout_byp",   {24'h0, d_out_b}, {24'h0, m_d1});
      check("dout_nobyp", {24'h0, d_out_n}, {24'h0, m_d0});
      check("rvalid_byp",   {31'h0, rv_b},   {31'h0, m_rv});
      check("rvalid_nobyp", {31'h0, rv_n},   {31'h0, m_rv});
      check("busy",  {31'h0, busy_b}, {31'h0, m_busy});
      check("busy_nobyp", {31'h0, busy_n}, {31'h0, m_busy});
      check("err",   {31'h0, err_b},  {31'h0, m_err});
      check("err_nobyp", {31'h0, err_n}, {31'h0, m_err});
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
   endtask

   // Asynchronous reset pulse placed between edges; effect checked at once.
   task automatic async_reset();
      r_en = 1'b0; w_en = 1'b0; clr = 1'b0;
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_busy",  {31'h0, busy_b}, 32'h0);
      check("rst_err",   {31'h0, err_b},  32'h0);
      check("rst_rvalid", {31'h0, rv_b},  32'h0);
      check("rst_dout",  {24'h0, d_out_b}, 32'h0);
      check("rst_dout_nobyp", {24'h0, d_out_n}, 32'h0);
      #2 rst_n = 1'b1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 3'(i), 8'($urandom_range(1, 255)), 8'hFF);
      end
   endtask

   task automatic read_all_zero(input string name);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 3'(i), 8'h00, 8'h00);
         check(name, {24'h0, d_out_b}, 32'h0);
      end
   endtask

   initial begin
      int busy_cycles;
      int guard;

      // r   w   c   a     d      m      d1     d0     rv
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 8'hDD, 8'hFF, 8'h00, 8'h00, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h00, 8'hDD, 8'hDD, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd3, 8'h03, 8'hFF, 8'hDD, 8'hDD, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'd3, 8'hFF, 8'hF0, 8'hDD, 8'hDD, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 8'h00, 8'hF3, 8'hF3, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd6, 8'h11, 8'hFF, 8'hF3, 8'hF3, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 3'd6, 8'hFF, 8'hFF, 8'hFF, 8'h11, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd5, 8'hAA, 8'h0F, 8'h0A, 8'h00, 1'b1};

      rst_n = 1'b0;
      r_en = 1'b0; w_en = 1'b0; clr = 1'b0;
      addr = 3'd0; d_in = 8'h00; wmask = 8'h00;
      model_reset();
      #2;
      check("por_dout",  {24'h0, d_out_b}, 32'h0);
      check("por_rvalid", {31'h0, rv_b},   32'h0);
      check("por_busy",  {31'h0, busy_b},  32'h0);
      check("por_err",   {31'h0, err_b},   32'h0);
      #21 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors
      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].r, vecs[i].w, vecs[i].c, vecs[i].a, vecs[i].d, vecs[i].m);
         check("tbl_dout_byp",   {24'h0, d_out_b}, {24'h0, vecs[i].exp_d1});
         check("tbl_dout_nobyp", {24'h0, d_out_n}, {24'h0, vecs[i].exp_d0});
         check("tbl_rvalid",     {31'h0, rv_b},    {31'h0, vecs[i].exp_rv});
      end

      // full sweep with a dropped write and an ignored re-clear
      fill_random();
      cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00);
      busy_cycles = 0;
      guard = 0;
      while (busy_b === 1'b1 && guard < 20) begin
         busy_cycles++;
         if (guard == 0)      cycle(1'b0, 1'b1, 1'b0, 3'd1, 8'h5A, 8'hFF);
         else if (guard == 2) cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00);
         else                 idle();
         guard++;
      end
      check("busy_len", 32'(busy_cycles), 32'd8);
      check("sweep_err", {31'h0, err_b}, 32'h1);
      idle();
      check("sweep_idle_busy", {31'h0, busy_b}, 32'h0);
      read_all_zero("sweep_read");

      // clear competing with a read in the same cycle
      async_reset();
      cycle(1'b1, 1'b0, 1'b1, 3'd2, 8'h00, 8'h00);
      check("clr_rw_err", {31'h0, err_b}, 32'h1);
      check("clr_rw_rvalid", {31'h0, rv_b}, 32'h0);
      for (int i = 0; i < 8; i++) idle();

      // reset in the middle of a sweep (pointer at 4)
      async_reset();
      fill_random();
      cycle(1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, 3'd7, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) idle();
      check("mid_busy_before", {31'h0, busy_b}, 32'h1);
      async_reset();
      idle();
      read_all_zero("midrst_read");
      cycle(1'b0, 1'b1, 1'b0, 3'd4, 8'h3C, 8'hFF);
      cycle(1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 8'h00);
      check("midrst_rw", {24'h0, d_out_b}, 32'h3C);

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         if (i == 200) async_reset();
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 19) == 0),
               3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
